// File: rtl/serial_sub2.sv
// serial_sub2: two-channel bit-serial subtractor, LSB-first, one bit per clock.
// S1 = A - B and S2 = C - D as (W+1)-bit {borrow, difference}.
// Optional feature macro: SUB_OVF_EN adds signed-overflow flags o_ovf1/o_ovf2.
module serial_sub2 #(
    parameter int unsigned W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    input  logic [W-1:0] i_d,
    output logic         o_busy,
    output logic         o_done,
    output logic [W:0]   o_s1,
`ifdef SUB_OVF_EN
    output logic [W:0]   o_s2,
    output logic         o_ovf1,
    output logic         o_ovf2
`else
    output logic [W:0]   o_s2
`endif
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(W - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_a, r_b, r_c, r_d;
    logic [W-1:0]  r_diff1, r_diff2;
    logic          r_bin1, r_bin2;
    logic [CW-1:0] r_cnt;
    logic [W:0]    r_s1, r_s2;
    logic          w_last;
    logic          w_d1, w_d2, w_bo1, w_bo2;
`ifdef SUB_OVF_EN
    logic          r_ovf1, r_ovf2;
`endif

    // Full-subtractor cell per channel on the current operand LSBs
    assign w_d1  = r_a[0] ^ r_b[0] ^ r_bin1;
    assign w_bo1 = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bin1);
    assign w_d2  = r_c[0] ^ r_d[0] ^ r_bin2;
    assign w_bo2 = (~r_c[0] & r_d[0]) | (~(r_c[0] ^ r_d[0]) & r_bin2);
    assign w_last = (r_cnt == LastCnt);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start only matters in idle, done always returns to idle
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_nxt = StShift;
            StShift: if (w_last) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Datapath: operand capture, serial ripple, result load on the last bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_diff1 <= '0;
            r_diff2 <= '0;
            r_bin1  <= 1'b0;
            r_bin2  <= 1'b0;
            r_cnt   <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
`ifdef SUB_OVF_EN
            r_ovf1  <= 1'b0;
            r_ovf2  <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_c     <= i_c;
                        r_d     <= i_d;
                        r_diff1 <= '0;
                        r_diff2 <= '0;
                        r_bin1  <= 1'b0;
                        r_bin2  <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                StShift: begin
                    r_a     <= {1'b0, r_a[W-1:1]};
                    r_b     <= {1'b0, r_b[W-1:1]};
                    r_c     <= {1'b0, r_c[W-1:1]};
                    r_d     <= {1'b0, r_d[W-1:1]};
                    r_diff1 <= {w_d1, r_diff1[W-1:1]};
                    r_diff2 <= {w_d2, r_diff2[W-1:1]};
                    r_bin1  <= w_bo1;
                    r_bin2  <= w_bo2;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_s1 <= {w_bo1, w_d1, r_diff1[W-1:1]};
                        r_s2 <= {w_bo2, w_d2, r_diff2[W-1:1]};
`ifdef SUB_OVF_EN
                        // On the last bit the operand LSBs are the original sign bits
                        r_ovf1 <= (r_a[0] ^ r_b[0]) & (w_d1 ^ r_a[0]);
                        r_ovf2 <= (r_c[0] ^ r_d[0]) & (w_d2 ^ r_c[0]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != StIdle);
    assign o_done = (r_state == StDone);
    assign o_s1   = r_s1;
    assign o_s2   = r_s2;
`ifdef SUB_OVF_EN
    assign o_ovf1 = r_ovf1;
    assign o_ovf2 = r_ovf2;
`endif

endmodule

// File: tb/tb_serial_sub2.sv
// Bench for serial_sub2: W=4 and W=8 instances against an arithmetic reference model.
module tb_serial_sub2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i4_start = 1'b0, i8_start = 1'b0;
    logic [3:0] i4_a = '0, i4_b = '0, i4_c = '0, i4_d = '0;
    logic [7:0] i8_a = '0, i8_b = '0, i8_c = '0, i8_d = '0;
    logic       o4_busy, o4_done, o8_busy, o8_done;
    logic [4:0] o4_s1, o4_s2;
    logic [8:0] o8_s1, o8_s2;
`ifdef SUB_OVF_EN
    logic       o4_ovf1, o4_ovf2, o8_ovf1, o8_ovf2;
`endif

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    serial_sub2 #(.W(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i4_start),
        .i_a(i4_a), .i_b(i4_b), .i_c(i4_c), .i_d(i4_d),
        .o_busy(o4_busy), .o_done(o4_done), .o_s1(o4_s1),
`ifdef SUB_OVF_EN
        .o_s2(o4_s2), .o_ovf1(o4_ovf1), .o_ovf2(o4_ovf2)
`else
        .o_s2(o4_s2)
`endif
    );

    serial_sub2 #(.W(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i8_start),
        .i_a(i8_a), .i_b(i8_b), .i_c(i8_c), .i_d(i8_d),
        .o_busy(o8_busy), .o_done(o8_done), .o_s1(o8_s1),
`ifdef SUB_OVF_EN
        .o_s2(o8_s2), .o_ovf1(o8_ovf1), .o_ovf2(o8_ovf2)
`else
        .o_s2(o8_s2)
`endif
    );

    // Reference: zero-extended subtraction kept to W+1 bits
    function automatic int unsigned ref_sub(input int unsigned a, input int unsigned b,
                                            input int unsigned w);
        return (a - b) & ((32'd1 << (w + 1)) - 1);
    endfunction

    // Reference: signed W-bit difference falls outside the W-bit signed range
    function automatic bit ref_ovf(input int unsigned a, input int unsigned b,
                                   input int unsigned w);
        int sa, sb, r, half;
        half = 1 << (w - 1);
        sa = (a >= half) ? int'(a) - 2 * half : int'(a);
        sb = (b >= half) ? int'(b) - 2 * half : int'(b);
        r = sa - sb;
        return (r > half - 1) || (r < -half);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One operation; optionally disturbs operands and pulses start mid-shift
    task automatic run_op(input bit wide, input int unsigned a, input int unsigned b,
                          input int unsigned c, input int unsigned d, input bit interfere);
        int unsigned w;
        int n;
        logic dn;
        w = wide ? 8 : 4;
        @(negedge clk);
        if (wide) begin
            i8_a = a[7:0]; i8_b = b[7:0]; i8_c = c[7:0]; i8_d = d[7:0]; i8_start = 1'b1;
        end else begin
            i4_a = a[3:0]; i4_b = b[3:0]; i4_c = c[3:0]; i4_d = d[3:0]; i4_start = 1'b1;
        end
        @(posedge clk); #1;
        i4_start = 1'b0;
        i8_start = 1'b0;
        n = 0;
        dn = 1'b0;
        while (!dn && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (interfere && n == 2) begin
                i4_a = 4'($urandom); i4_b = 4'($urandom); i4_c = 4'($urandom);
                i4_d = 4'($urandom); i8_a = 8'($urandom); i8_b = 8'($urandom);
                i8_c = 8'($urandom); i8_d = 8'($urandom);
                i4_start = !wide;
                i8_start = wide;
            end
            if (interfere && n == 3) begin
                i4_start = 1'b0;
                i8_start = 1'b0;
            end
            dn = wide ? o8_done : o4_done;
        end
        chk("latency", n, w);
        chk("s1", wide ? 32'(o8_s1) : 32'(o4_s1), ref_sub(a, b, w));
        chk("s2", wide ? 32'(o8_s2) : 32'(o4_s2), ref_sub(c, d, w));
`ifdef SUB_OVF_EN
        chk("ovf1", wide ? 32'(o8_ovf1) : 32'(o4_ovf1), 32'(ref_ovf(a, b, w)));
        chk("ovf2", wide ? 32'(o8_ovf2) : 32'(o4_ovf2), 32'(ref_ovf(c, d, w)));
`endif
        chk("busy_in_done", wide ? 32'(o8_busy) : 32'(o4_busy), 32'd1);
        @(posedge clk); #1;
        chk("done_pulse", wide ? 32'(o8_done) : 32'(o4_done), 32'd0);
        chk("busy_after", wide ? 32'(o8_busy) : 32'(o4_busy), 32'd0);
        if (interfere) begin
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                chk("no_queued_op", wide ? 32'(o8_busy | o8_done) : 32'(o4_busy | o4_done),
                    32'd0);
            end
        end
    endtask

    initial begin
        int unsigned ra[3], rb[3], rc[3], rd[3];
        int prev, n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy4", o4_busy, 1'b0);
        chk("rst_done4", o4_done, 1'b0);
        chk("rst_s1_4", o4_s1, 5'd0);
        chk("rst_s2_4", o4_s2, 5'd0);
        chk("rst_s1_8", o8_s1, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(1'b0, 5, 2, 6, 12, 1'b0);
        run_op(1'b0, 1, 6, 0, 14, 1'b0);
        run_op(1'b0, 14, 15, 13, 6, 1'b0);
        run_op(1'b1, 200, 55, 0, 1, 1'b0);
        run_op(1'b0, 0, 0, 15, 15, 1'b0);
        run_op(1'b0, 15, 0, 0, 15, 1'b0);

        // Second start during shift is ignored and operand changes do not leak in
        run_op(1'b0, 9, 3, 4, 11, 1'b1);

        // Back-to-back with start held high
        for (int k = 0; k < 3; k++) begin
            ra[k] = $urandom_range(15); rb[k] = $urandom_range(15);
            rc[k] = $urandom_range(15); rd[k] = $urandom_range(15);
        end
        @(negedge clk);
        i4_a = ra[0][3:0]; i4_b = rb[0][3:0]; i4_c = rc[0][3:0]; i4_d = rd[0][3:0];
        i4_start = 1'b1;
        prev = -1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!o4_done && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("b2b_done_seen", o4_done, 1'b1);
            chk("b2b_s1", o4_s1, ref_sub(ra[k], rb[k], 4));
            chk("b2b_s2", o4_s2, ref_sub(rc[k], rd[k], 4));
            if (prev >= 0) chk("b2b_period", cyc_cnt - prev, 6);
            prev = cyc_cnt;
            @(posedge clk); #1;
            chk("b2b_idle_gap", o4_busy, 1'b0);
            if (k < 2) begin
                i4_a = ra[k+1][3:0]; i4_b = rb[k+1][3:0];
                i4_c = rc[k+1][3:0]; i4_d = rd[k+1][3:0];
            end else begin
                i4_start = 1'b0;
            end
        end
        @(posedge clk); #1;
        chk("b2b_stopped", o4_busy, 1'b0);

        // Asynchronous reset mid-shift
        @(negedge clk);
        i4_a = 4'd7; i4_b = 4'd1; i4_c = 4'd3; i4_d = 4'd2;
        i4_start = 1'b1;
        @(posedge clk); #1;
        i4_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", o4_busy, 1'b0);
        chk("arst_done", o4_done, 1'b0);
        chk("arst_s1", o4_s1, 5'd0);
        chk("arst_s2", o4_s2, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 5, 2, 6, 12, 1'b0);

        // Randomized operations on both widths
        for (int i = 0; i < 20; i++) begin
            run_op(1'b0, $urandom_range(15), $urandom_range(15), $urandom_range(15),
                   $urandom_range(15), 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            run_op(1'b1, $urandom_range(255), $urandom_range(255), $urandom_range(255),
                   $urandom_range(255), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
